// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the combinational memory port: one request, one access, one response.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests skip memory and report resp_misalign instead of being force-aligned.
module lsu_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_is_store,
    output logic             resp_misalign,
    output logic [XLEN-1:0]  mem_addr,
    output logic             mem_ce,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [7:0]       mem_wmask,
    input  logic [XLEN-1:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic             we;
        logic [1:0]       size;
        logic             uns;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
        logic [TAG_W-1:0] tag;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              mis_q, mis_d;

    logic [2:0]        lsb_mask;
    logic              misal;
    logic [2:0]        off;
    logic [7:0]        base_mask;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   load_ext;
    logic              in_access, in_resp;

    // Address bits that must be zero for a naturally aligned access of req_size.
    always_comb begin
        case (req_size)
            2'd0:    lsb_mask = 3'b000;
            2'd1:    lsb_mask = 3'b001;
            2'd2:    lsb_mask = 3'b011;
            default: lsb_mask = 3'b111;
        endcase
    end
    assign misal = |(req_addr[2:0] & lsb_mask);

    assign off       = req_q.addr[2:0];
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    always_comb begin
        case (req_q.size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    assign raw = mem_rdata >> {off, 3'b000};
    always_comb begin
        case (req_q.size)
            2'd0:    load_ext = {{56{raw[7]  & ~req_q.uns}}, raw[7:0]};
            2'd1:    load_ext = {{48{raw[15] & ~req_q.uns}}, raw[15:0]};
            2'd2:    load_ext = {{32{raw[31] & ~req_q.uns}}, raw[31:0]};
            default: load_ext = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.size  = req_size;
                    req_d.uns   = req_unsigned;
                    req_d.wdata = req_wdata;
                    req_d.tag   = req_tag;
                    data_d      = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    req_d.addr  = req_addr;
                    mis_d       = misal;
                    state_d     = misal ? RESP : ACCESS;
`else
                    req_d.addr  = {req_addr[XLEN-1:3], req_addr[2:0] & ~lsb_mask};
                    mis_d       = 1'b0;
                    state_d     = ACCESS;
`endif
                end
            end
            ACCESS: begin
                data_d  = req_q.we ? '0 : load_ext;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
        end
    end

    // Memory port is fully quiet outside the single ACCESS cycle.
    assign mem_ce    = in_access;
    assign mem_we    = in_access & req_q.we;
    assign mem_addr  = in_access ? {req_q.addr[XLEN-1:3], 3'b000} : '0;
    assign mem_wmask = (in_access & req_q.we) ? (base_mask << off) : 8'h00;
    assign mem_wdata = (in_access & req_q.we) ? (req_q.wdata << {off, 3'b000}) : '0;

    assign req_ready     = (state_q == IDLE) & ~reset;
    assign resp_valid    = in_resp;
    assign resp_data     = in_resp ? data_q : '0;
    assign resp_tag      = in_resp ? req_q.tag : '0;
    assign resp_is_store = in_resp & req_q.we;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_misalign = in_resp & mis_q;
`else
    assign resp_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: memory-side checks during ACCESS, scoreboard of expected responses.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        resp_valid, resp_ready, resp_is_store, resp_misalign;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ce, mem_we;
    logic [7:0]  mem_wmask;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        st;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    lsu_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_is_store(resp_is_store), .resp_misalign(resp_misalign),
        .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request; checks the memory port in the cycle after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] tag,
                         input logic [63:0] rdata, input logic [63:0] e_addr, input logic [7:0] e_mask,
                         input logic [63:0] e_wdata, input logic [63:0] e_data, input logic e_mis);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_tag = tag; mem_rdata = rdata;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        e.data = e_data; e.tag = tag; e.st = we; e.mis = e_mis;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (e_mis) begin
            chk("trap_mem_ce", {63'd0, mem_ce}, 64'd0);
        end else begin
            chk("mem_ce", {63'd0, mem_ce}, 64'd1);
            chk("mem_we", {63'd0, mem_we}, {63'd0, we});
            chk("mem_addr", mem_addr, e_addr);
            chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
            if (we) begin
                chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, e_mask});
                chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    endtask

    // Wait (bounded) for the response, compare against the scoreboard, optionally hold backpressure.
    task automatic get_resp(input int exp_lat, input int hold);
        exp_t e;
        int   lat = 0;
        while (!resp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_latency", 64'(lat), 64'(exp_lat));
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk("resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("resp_data", resp_data, e.data);
        chk("resp_tag", {59'd0, resp_tag}, {59'd0, e.tag});
        chk("resp_is_store", {63'd0, resp_is_store}, {63'd0, e.st});
        chk("resp_misalign", {63'd0, resp_misalign}, {63'd0, e.mis});
        chk("mem_ce_in_resp", {63'd0, mem_ce}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_data", resp_data, e.data);
            chk("bp_tag", {59'd0, resp_tag}, {59'd0, e.tag});
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("post_req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_tag = '0; resp_ready = 1'b1; mem_rdata = '0;
        #12;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_mem_ce", {63'd0, mem_ce}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        // dword store
        issue(1'b1, 2'd3, 1'b0, 64'h80000008, 64'h1122334455667788, 5'd1, 64'd0,
              64'h80000008, 8'hFF, 64'h1122334455667788, 64'd0, 1'b0);
        get_resp(1, 0);
        // byte store at lane 5
        issue(1'b1, 2'd0, 1'b0, 64'h80000005, 64'h00000000000000AB, 5'd2, 64'd0,
              64'h80000000, 8'h20, 64'h0000AB0000000000, 64'd0, 1'b0);
        get_resp(1, 0);
        // word store at lane 4
        issue(1'b1, 2'd2, 1'b0, 64'h80000014, 64'h00000000CAFEF00D, 5'd3, 64'd0,
              64'h80000010, 8'hF0, 64'hCAFEF00D00000000, 64'd0, 1'b0);
        get_resp(1, 0);
        // signed / unsigned half loads
        issue(1'b0, 2'd1, 1'b0, 64'h80000006, 64'd0, 5'd4, 64'h8001000000000000,
              64'h80000000, 8'h00, 64'd0, 64'hFFFFFFFFFFFF8001, 1'b0);
        get_resp(1, 0);
        issue(1'b0, 2'd1, 1'b1, 64'h80000006, 64'd0, 5'd5, 64'h8001000000000000,
              64'h80000000, 8'h00, 64'd0, 64'h0000000000008001, 1'b0);
        get_resp(1, 0);
        // signed byte load lane 3, dword load
        issue(1'b0, 2'd0, 1'b0, 64'h80000003, 64'd0, 5'd6, 64'h0000000080000000,
              64'h80000000, 8'h00, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0);
        get_resp(1, 0);
        issue(1'b0, 2'd3, 1'b0, 64'h80000018, 64'd0, 5'd7, 64'hA5A5_0F0F_1234_5678,
              64'h80000018, 8'h00, 64'd0, 64'hA5A5_0F0F_1234_5678, 1'b0);
        get_resp(1, 0);

        // backpressure on a signed word load
        resp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 64'h80000004, 64'd0, 5'd9, 64'hDEADBEEF00000000,
              64'h80000000, 8'h00, 64'd0, 64'hFFFFFFFFDEADBEEF, 1'b0);
        get_resp(1, 4);

        // misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 2'd2, 1'b0, 64'h80000002, 64'd0, 5'd10, 64'h000000007ABCDEF0,
              64'h0, 8'h00, 64'd0, 64'd0, 1'b1);
        get_resp(0, 0);
`else
        issue(1'b0, 2'd2, 1'b0, 64'h80000002, 64'd0, 5'd10, 64'h000000007ABCDEF0,
              64'h80000000, 8'h00, 64'd0, 64'h000000007ABCDEF0, 1'b0);
        get_resp(1, 0);
`endif

        // reset during ACCESS of a store
        issue(1'b1, 2'd3, 1'b0, 64'h80000020, 64'hFFFF0000FFFF0000, 5'd11, 64'd0,
              64'h80000020, 8'hFF, 64'hFFFF0000FFFF0000, 64'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("arst_mem_ce", {63'd0, mem_ce}, 64'd0);
        chk("arst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("arst_mem_addr", mem_addr, 64'd0);
        chk("arst_mem_wdata", mem_wdata, 64'd0);
        chk("arst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("arst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_req_ready", {63'd0, req_ready}, 64'd1);
        issue(1'b0, 2'd2, 1'b1, 64'h80000024, 64'd0, 5'd12, 64'h8765432100000000,
              64'h80000020, 8'h00, 64'd0, 64'h0000000087654321, 1'b0);
        get_resp(1, 0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
